stopwatch_timer: RTL and testbench
==================================

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 Parameter CLK_DIV, default 50000000: CLOCK_50 cycles per one-second tick.
REQ-002 Parameter DEB_CYCLES, default 1000000: cycles a raw button level must be stable to be accepted (20 ms).
REQ-003 Parameter MIN_MAX, default 59: highest minutes value, range 1..63.
REQ-004 CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 BUTTON  in  2  raw asynchronous keys, active-low; [1] start/stop, [0] clear.
REQ-007 MODE  in  1  0 = count up (stopwatch), 1 = count down (timer).
REQ-008 PRESET_MIN  in  6  countdown start minutes.
REQ-009 PRESET_SEC  in  6  countdown start seconds.
REQ-010 sec  out  6  seconds value, 0..59.
REQ-011 min  out  6  minutes value, 0..MIN_MAX.
REQ-012 running  out  1  high in RUN only.
REQ-013 done  out  1  high in DONE only.

Function
REQ-014 Each BUTTON bit SHALL pass a 2-FF synchroniser, then a debouncer; a press event is a one-cycle pulse on the debounced high-to-low transition.
REQ-015 Press-event latency SHALL be 2 + DEB_CYCLES + 1 cycles from a stable raw low level; bounces shorter than DEB_CYCLES SHALL produce no event.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-017 Clear event in any state -> IDLE; loads 00:00 if MODE=0, else the clamped preset.
REQ-018 Start/stop event: IDLE->RUN; RUN->PAUSE; PAUSE->RUN; ignored in DONE.
REQ-019 Clear and start/stop events in the same cycle: clear wins.
REQ-020 MODE SHALL be latched on IDLE->RUN; MODE changes outside IDLE have no effect until the next clear.
REQ-021 Preset clamp: PRESET_SEC>59 -> 59; PRESET_MIN>MIN_MAX -> MIN_MAX.
REQ-022 The prescaler SHALL count only in RUN and be zeroed on every entry to RUN; the first tick occurs exactly CLK_DIV cycles after entry. No derived clock; the tick is a clock enable.
REQ-023 Up tick: sec 59 -> 0 with min+1; at MIN_MAX:59 wrap to 00:00 and stay in RUN.
REQ-024 Down tick: sec 0 -> 59 with min-1; the tick reaching 00:00 SHALL enter DONE in the same edge.
REQ-025 Start from IDLE in down mode with value 00:00 SHALL go directly to DONE with no tick.
REQ-026 sec/min SHALL hold in PAUSE, IDLE and DONE.

Reset
REQ-027 RESET_N low SHALL immediately force IDLE, sec=0, min=0, running=0, done=0, prescaler=0, latched mode=0, synchronisers/debouncers to released (1).
REQ-028 Reset mid-count SHALL discard the count; the first event after release requires a full debounce.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the state enum and the constant SEC_MAX=59.
REQ-030 Sub-module btn_debounce (sync + debounce + press pulse, parameter DEB_CYCLES) SHALL be instantiated once per BUTTON bit.

Verification (CLK_DIV=10, DEB_CYCLES=4)
REQ-031 MODE=0, press start, wait 600 cycles -> 01:00, running=1; at 00:10 press start -> PAUSE, value held for 100 cycles.
REQ-032 MODE=1, preset 00:03, clear, start -> 00:02, 00:01, 00:00 at 10-cycle spacing; done=1 on the 00:00 edge; start ignored; clear -> IDLE, 00:03.
REQ-033 Raw BUTTON[1] low for 3 cycles, repeated 5 times -> no event; low for 8 cycles -> exactly one event, 7 cycles after the falling edge.
REQ-034 Both keys pressed simultaneously in RUN -> IDLE, 00:00, running=0.
REQ-035 MIN_MAX=2, up mode from 02:59 tick -> 00:00, still RUN; preset 63:63 in down mode -> loads 02:59.
REQ-036 RESET_N low asynchronously mid-RUN at 00:37 -> outputs zero before next edge; IDLE after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/timer block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/btn_debounce.sv
// One key input: 2-FF synchroniser, stability-counter debouncer and a
// one-cycle press pulse on the debounced high-to-low transition.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Synchronise, accept a new level after DEB_CYCLES identical samples,
    // then emit a registered pulse on the accepted falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_p0  <= btn_raw;
            sync_p1  <= sync_p0;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Up-counting stopwatch / down-counting timer, mm:ss, driven by two
// debounced active-low keys and a one-second clock-enable prescaler.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV    = 50000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int MIN_MAX    = 59
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [1:0] BUTTON,
    input  logic       MODE,
    input  logic [5:0] PRESET_MIN,
    input  logic [5:0] PRESET_SEC,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       running,
    output logic       done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [5:0]    MIN_MAX_V  = 6'(MIN_MAX);

    state_t        state, state_nxt;
    logic          mode_lat, mode_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [5:0]    sec_nxt, min_nxt;
    logic [1:0]    press_ev;
    logic          clr_ev, ss_ev, tick;

    function automatic logic [5:0] sat_lim(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (CLOCK_50),
            .rst_n  (RESET_N),
            .btn_raw(BUTTON[i]),
            .press  (press_ev[i])
        );
    end

    assign clr_ev  = press_ev[0];
    assign ss_ev   = press_ev[1];
    assign tick    = (state == RUN) && (presc == PRESC_LAST);
    assign running = (state == RUN);
    assign done    = (state == DONE);

    // Register FSM state, latched mode, prescaler and the mm:ss value.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            mode_lat <= 1'b0;
            presc    <= '0;
            sec      <= '0;
            min      <= '0;
        end else begin
            state    <= state_nxt;
            mode_lat <= mode_nxt;
            presc    <= presc_nxt;
            sec      <= sec_nxt;
            min      <= min_nxt;
        end
    end

    // Next state and value: clear beats start/stop, and a key event in the
    // same cycle as a tick takes precedence over the tick.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_lat;
        presc_nxt = presc;
        sec_nxt   = sec;
        min_nxt   = min;
        if (state == RUN) begin
            presc_nxt = tick ? '0 : presc + 1'b1;
        end
        if (clr_ev) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            if (MODE) begin
                sec_nxt = sat_lim(PRESET_SEC, SEC_MAX);
                min_nxt = sat_lim(PRESET_MIN, MIN_MAX_V);
            end else begin
                sec_nxt = '0;
                min_nxt = '0;
            end
        end else if (ss_ev) begin
            case (state)
                IDLE: begin
                    mode_nxt  = MODE;
                    presc_nxt = '0;
                    state_nxt = (MODE && sec == 6'd0 && min == 6'd0) ? DONE : RUN;
                end
                RUN:     state_nxt = PAUSE;
                PAUSE: begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
                default: state_nxt = state;
            endcase
        end else if (tick) begin
            if (!mode_lat) begin
                if (sec == SEC_MAX) begin
                    sec_nxt = '0;
                    min_nxt = (min == MIN_MAX_V) ? 6'd0 : min + 6'd1;
                end else begin
                    sec_nxt = sec + 6'd1;
                end
            end else begin
                if (sec == 6'd0) begin
                    sec_nxt = SEC_MAX;
                    min_nxt = min - 6'd1;
                end else begin
                    sec_nxt = sec - 6'd1;
                end
                if (min == 6'd0 && sec == 6'd1) begin
                    state_nxt = DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer with CLK_DIV=10, DEB_CYCLES=4.
module tb_stopwatch_timer;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic       running;
        logic       done;
    } snap_t;

    typedef struct {
        string name;
        snap_t v;
    } item_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [1:0] BUTTON;
    logic       MODE;
    logic [5:0] PRESET_MIN, PRESET_SEC;
    logic [5:0] sec1, min1;
    logic       running1, done1;

    logic [1:0] button2;
    logic       mode2;
    logic [5:0] preset_min2, preset_sec2;
    logic [5:0] sec2, min2;
    logic       running2, done2;

    item_t exp_q[$];
    snap_t obs_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    stopwatch_timer #(.CLK_DIV(10), .DEB_CYCLES(4), .MIN_MAX(59)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .BUTTON    (BUTTON),
        .MODE      (MODE),
        .PRESET_MIN(PRESET_MIN),
        .PRESET_SEC(PRESET_SEC),
        .sec       (sec1),
        .min       (min1),
        .running   (running1),
        .done      (done1)
    );

    stopwatch_timer #(.CLK_DIV(10), .DEB_CYCLES(4), .MIN_MAX(2)) dut2 (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .BUTTON    (button2),
        .MODE      (mode2),
        .PRESET_MIN(preset_min2),
        .PRESET_SEC(preset_sec2),
        .sec       (sec2),
        .min       (min2),
        .running   (running2),
        .done      (done2)
    );

    function automatic item_t mk(input string n, input int m, input int s, input bit r, input bit d);
        item_t x;
        x.name      = n;
        x.v.min     = 6'(m);
        x.v.sec     = 6'(s);
        x.v.running = r;
        x.v.done    = d;
        return x;
    endfunction

    function automatic snap_t snap1();
        return {min1, sec1, running1, done1};
    endfunction

    function automatic snap_t snap2();
        return {min2, sec2, running2, done2};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Hold a key low long enough for one event; returns just after the FSM edge.
    task automatic press(input int idx);
        BUTTON[idx] = 1'b0;
        cyc(8);
        BUTTON[idx] = 1'b1;
    endtask

    task automatic press2(input int idx);
        button2[idx] = 1'b0;
        cyc(8);
        button2[idx] = 1'b1;
    endtask

    task automatic test_reset();
        item_t it;
        snap_t got;
        RESET_N = 1'b0;
        BUTTON = 2'b11; MODE = 1'b0; PRESET_MIN = '0; PRESET_SEC = '0;
        button2 = 2'b11; mode2 = 1'b0; preset_min2 = '0; preset_sec2 = '0;
        exp_q.push_back(mk("rst_dut", 0, 0, 0, 0));
        exp_q.push_back(mk("rst_dut2", 0, 0, 0, 0));
        cyc(2);
        obs_q.push_back(snap1());
        obs_q.push_back(snap2());
        #3 RESET_N = 1'b1;
        exp_q.push_back(mk("rst_release", 0, 0, 0, 0));
        cyc(2);
        obs_q.push_back(snap1());
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    task automatic test_up_count();
        item_t it;
        snap_t got;
        cyc(8);
        MODE = 1'b0;
        exp_q.push_back(mk("up_start", 0, 0, 1, 0));   press(1);  obs_q.push_back(snap1());
        exp_q.push_back(mk("up_00_59", 0, 59, 1, 0));  cyc(599); obs_q.push_back(snap1());
        exp_q.push_back(mk("up_01_00", 1, 0, 1, 0));   cyc(1);   obs_q.push_back(snap1());
        exp_q.push_back(mk("up_clear", 0, 0, 0, 0));   press(0);  obs_q.push_back(snap1());
        cyc(8);
        exp_q.push_back(mk("up_restart", 0, 0, 1, 0)); press(1);  obs_q.push_back(snap1());
        exp_q.push_back(mk("up_00_09", 0, 9, 1, 0));   cyc(99);  obs_q.push_back(snap1());
        exp_q.push_back(mk("up_00_10", 0, 10, 1, 0));  cyc(1);   obs_q.push_back(snap1());
        exp_q.push_back(mk("pause", 0, 10, 0, 0));     press(1);  obs_q.push_back(snap1());
        exp_q.push_back(mk("pause_hold", 0, 10, 0, 0)); cyc(100); obs_q.push_back(snap1());
        exp_q.push_back(mk("resume", 0, 10, 1, 0));    press(1);  obs_q.push_back(snap1());
        exp_q.push_back(mk("resume_9cyc", 0, 10, 1, 0)); cyc(9); obs_q.push_back(snap1());
        exp_q.push_back(mk("resume_10cyc", 0, 11, 1, 0)); cyc(1); obs_q.push_back(snap1());
        exp_q.push_back(mk("up_end_clear", 0, 0, 0, 0)); press(0); obs_q.push_back(snap1());
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    task automatic test_countdown();
        item_t it;
        snap_t got;
        cyc(8);
        MODE = 1'b1; PRESET_MIN = 6'd0; PRESET_SEC = 6'd3;
        exp_q.push_back(mk("dn_clear", 0, 3, 0, 0));    press(0); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_start", 0, 3, 1, 0));    press(1); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_00_02", 0, 2, 1, 0));    cyc(10); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_00_01", 0, 1, 1, 0));    cyc(10); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_pre_done", 0, 1, 1, 0)); cyc(9);  obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_done", 0, 0, 0, 1));     cyc(1);  obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_start_ignored", 0, 0, 0, 1)); press(1); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_reclear", 0, 3, 0, 0));  press(0); obs_q.push_back(snap1());
        PRESET_MIN = 6'd1; PRESET_SEC = 6'd0;
        cyc(8);
        exp_q.push_back(mk("dn_load_01_00", 1, 0, 0, 0)); press(0); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_start_01_00", 1, 0, 1, 0)); press(1); obs_q.push_back(snap1());
        MODE = 1'b0;
        exp_q.push_back(mk("dn_mode_latched", 0, 59, 1, 0)); cyc(10); obs_q.push_back(snap1());
        MODE = 1'b1; PRESET_MIN = 6'd0; PRESET_SEC = 6'd0;
        exp_q.push_back(mk("dn_load_zero", 0, 0, 0, 0)); press(0); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_zero_start", 0, 0, 0, 1)); press(1); obs_q.push_back(snap1());
        exp_q.push_back(mk("dn_zero_hold", 0, 0, 0, 1)); cyc(20); obs_q.push_back(snap1());
        PRESET_MIN = 6'd63; PRESET_SEC = 6'd63;
        exp_q.push_back(mk("dn_clamp", 59, 59, 0, 0)); press(0); obs_q.push_back(snap1());
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    task automatic test_bounce();
        item_t it;
        snap_t got;
        cyc(8);
        MODE = 1'b0;
        exp_q.push_back(mk("b_clear", 0, 0, 0, 0)); press(0); obs_q.push_back(snap1());
        for (int i = 0; i < 5; i++) begin
            BUTTON[1] = 1'b0; cyc(3);
            BUTTON[1] = 1'b1; cyc(3);
        end
        exp_q.push_back(mk("b_no_event", 0, 0, 0, 0)); cyc(10); obs_q.push_back(snap1());
        BUTTON[1] = 1'b0;
        exp_q.push_back(mk("b_edge7_idle", 0, 0, 0, 0)); cyc(7); obs_q.push_back(snap1());
        exp_q.push_back(mk("b_edge8_run", 0, 0, 1, 0));  cyc(1); obs_q.push_back(snap1());
        BUTTON[1] = 1'b1;
        exp_q.push_back(mk("b_single_event", 0, 2, 1, 0)); cyc(20); obs_q.push_back(snap1());
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    task automatic test_both_keys();
        item_t it;
        snap_t got;
        BUTTON = 2'b00;
        exp_q.push_back(mk("both_clear_wins", 0, 0, 0, 0)); cyc(8); obs_q.push_back(snap1());
        BUTTON = 2'b11;
        exp_q.push_back(mk("both_hold", 0, 0, 0, 0)); cyc(20); obs_q.push_back(snap1());
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    task automatic test_minmax();
        item_t it;
        snap_t got;
        mode2 = 1'b0;
        exp_q.push_back(mk("mm_start", 0, 0, 1, 0));  press2(1);  obs_q.push_back(snap2());
        exp_q.push_back(mk("mm_02_59", 2, 59, 1, 0)); cyc(1790); obs_q.push_back(snap2());
        exp_q.push_back(mk("mm_wrap", 0, 0, 1, 0));   cyc(10);   obs_q.push_back(snap2());
        exp_q.push_back(mk("mm_after_wrap", 0, 1, 1, 0)); cyc(10); obs_q.push_back(snap2());
        mode2 = 1'b1; preset_min2 = 6'd63; preset_sec2 = 6'd63;
        exp_q.push_back(mk("mm_clamp", 2, 59, 0, 0)); press2(0); obs_q.push_back(snap2());
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    task automatic test_reset_mid();
        item_t it;
        snap_t got;
        cyc(8);
        MODE = 1'b0;
        exp_q.push_back(mk("rm_clear", 0, 0, 0, 0)); press(0); obs_q.push_back(snap1());
        exp_q.push_back(mk("rm_start", 0, 0, 1, 0)); press(1); obs_q.push_back(snap1());
        exp_q.push_back(mk("rm_00_37", 0, 37, 1, 0)); cyc(370); obs_q.push_back(snap1());
        BUTTON[1] = 1'b0;
        #3 RESET_N = 1'b0;
        exp_q.push_back(mk("rm_async_zero", 0, 0, 0, 0));
        #1 obs_q.push_back(snap1());
        exp_q.push_back(mk("rm_held", 0, 0, 0, 0)); cyc(3); obs_q.push_back(snap1());
        #4 RESET_N = 1'b1;
        exp_q.push_back(mk("rm_full_debounce", 0, 0, 0, 0)); cyc(7); obs_q.push_back(snap1());
        exp_q.push_back(mk("rm_first_event", 0, 0, 1, 0));   cyc(1); obs_q.push_back(snap1());
        BUTTON[1] = 1'b1;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 'x;
            total++;
            if (got !== it.v) begin
                bad++;
                $display("FAIL %s: got %0d:%0d run=%0b done=%0b, want %0d:%0d run=%0b done=%0b", it.name,
                         got.min, got.sec, got.running, got.done, it.v.min, it.v.sec, it.v.running, it.v.done);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_up_count();
        test_countdown();
        test_bounce();
        test_both_keys();
        test_minmax();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
